// File: rtl/bus_arbiter_wb8.sv
// bus_arbiter_wb8: two-master round-robin arbiter in front of the shared 8-bit
// Wishbone slave bus. M0 is the spu32 CPU and M1 is the DMA/debug master. A grant
// lasts for the whole CYC of its owner. Between owners there is always one IDLE cycle.
// Optional feature macro: BUS_ARB_TIMEOUT_EN adds a watchdog and the O_timeout port.
// The watchdog ends transfers that a slave never acknowledges, using the
// TIMEOUT / TIMEOUT_DAT parameters.
module bus_arbiter_wb8
#(
    parameter int         TIMEOUT     = 64,
    parameter logic [7:0] TIMEOUT_DAT = 8'hFF
)
(
    input  logic        I_wb_clk,
    input  logic        I_reset,
    input  logic [1:0]  I_m_cyc,
    input  logic [1:0]  I_m_stb,
    input  logic [1:0]  I_m_we,
    input  logic [63:0] I_m_adr,
    input  logic [15:0] I_m_dat,
    output logic [7:0]  O_m_dat,
    output logic [1:0]  O_m_ack,
    output logic [1:0]  O_m_stall,
    output logic        O_s_cyc,
    output logic        O_s_stb,
    output logic        O_s_we,
    output logic [31:0] O_s_adr,
    output logic [7:0]  O_s_dat,
    input  logic [7:0]  I_s_dat,
    input  logic        I_s_ack,
    input  logic        I_s_stall,
    output logic [1:0]  O_grant
`ifdef BUS_ARB_TIMEOUT_EN
    ,
    output logic        O_timeout
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } state_t;

    state_t state_q, state_d;
    logic   lastOwner_q, lastOwner_d;
    logic   pending_q, pending_d;

    logic        owning;
    logic        ownerIdx;
    logic        selCyc;
    logic        selStb;
    logic        selWe;
    logic [31:0] selAdr;
    logic [7:0]  selDat;
    logic        xferDone;
    logic        ackOut;

`ifdef BUS_ARB_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    logic [7:0] count_q, count_d;
    logic       timeoutFire;
`endif

    // The owner's request signals, picked out by the registered state.
    always_comb begin
        owning   = (state_q != IDLE);
        ownerIdx = (state_q == OWN1);
        selCyc   = I_m_cyc[ownerIdx];
        selStb   = I_m_stb[ownerIdx];
        selWe    = I_m_we[ownerIdx];
        selAdr   = ownerIdx ? I_m_adr[63:32] : I_m_adr[31:0];
        selDat   = ownerIdx ? I_m_dat[15:8] : I_m_dat[7:0];
    end

`ifdef BUS_ARB_TIMEOUT_EN
    // The watchdog completes a stuck transfer, unless the slave acks on that same cycle.
    // An ack that arrives while nothing is pending is dropped.
    always_comb begin
        timeoutFire = pending_q & ~I_s_ack & (count_q == TIMEOUT_LAST);
        ackOut      = (pending_q & I_s_ack) | timeoutFire;
        xferDone    = ackOut;
        O_timeout   = owning & timeoutFire;
    end
`else
    // Without the watchdog, the slave ack is the only way a transfer completes.
    always_comb begin
        ackOut   = I_s_ack;
        xferDone = I_s_ack;
    end
`endif

    // Route the owner onto the slave bus. Everyone else sees stall.
    // While a transfer is pending, the owner is stalled so it cannot issue a second strobe.
    always_comb begin
        O_s_cyc   = 1'b0;
        O_s_stb   = 1'b0;
        O_s_we    = 1'b0;
        O_s_adr   = 32'd0;
        O_s_dat   = 8'd0;
        O_m_ack   = 2'b00;
        O_m_stall = 2'b11;
        O_m_dat   = I_s_dat;
        if (owning) begin
            O_s_cyc             = selCyc;
            O_s_stb             = selStb & ~pending_q;
            O_s_we              = selWe;
            O_s_adr             = selAdr;
            O_s_dat             = selDat;
            O_m_stall[ownerIdx] = pending_q | I_s_stall;
            O_m_ack[ownerIdx]   = ackOut;
`ifdef BUS_ARB_TIMEOUT_EN
            if (timeoutFire) begin
                O_m_dat = TIMEOUT_DAT;
            end
`endif
        end
    end

    // Round-robin ownership and single-transfer pending tracking.
    // If the owner drops CYC, the state goes to IDLE and any outstanding ack is forgotten.
    always_comb begin
        state_d     = state_q;
        lastOwner_d = lastOwner_q;
        pending_d   = pending_q;
        case (state_q)
            IDLE: begin
                pending_d = 1'b0;
                if (&I_m_cyc) begin
                    state_d = lastOwner_q ? OWN0 : OWN1;
                end else if (I_m_cyc[0]) begin
                    state_d = OWN0;
                end else if (I_m_cyc[1]) begin
                    state_d = OWN1;
                end
            end
            OWN0, OWN1: begin
                if (!selCyc) begin
                    state_d     = IDLE;
                    lastOwner_d = ownerIdx;
                    pending_d   = 1'b0;
                end else if (pending_q) begin
                    if (xferDone) begin
                        pending_d = 1'b0;
                    end
                end else if (selStb && !I_s_stall) begin
                    pending_d = 1'b1;
                end
            end
            default: begin
                state_d   = IDLE;
                pending_d = 1'b0;
            end
        endcase
    end

`ifdef BUS_ARB_TIMEOUT_EN
    // The watchdog counter runs only while the same transfer stays pending.
    always_comb begin
        count_d = (pending_q && pending_d) ? count_q + 8'd1 : 8'd0;
    end
`endif

    // State registers with synchronous reset. M0 wins the first tie.
    always_ff @(posedge I_wb_clk) begin
        if (I_reset) begin
            state_q     <= IDLE;
            lastOwner_q <= 1'b1;
            pending_q   <= 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
            count_q     <= 8'd0;
`endif
        end else begin
            state_q     <= state_d;
            lastOwner_q <= lastOwner_d;
            pending_q   <= pending_d;
`ifdef BUS_ARB_TIMEOUT_EN
            count_q     <= count_d;
`endif
        end
    end

    assign O_grant = state_q;

endmodule
